// File: rtl/cache_refill_ctrl_if.sv
// Miss/refill and memory-side bus bundle for cache_refill_ctrl.
// master: the refill controller. slave: the cache bank plus memory adapter.
interface cache_refill_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BANK_NUM   = 4
);
  // Cache bank miss side
  logic                           miss_cache;
  logic [ADDR_WIDTH-1:0]          addr_cache;
  logic                           set_cache;
  logic                           need_wb;
  logic [ADDR_WIDTH-1:0]          addr_wb;
  logic [BANK_NUM*DATA_WIDTH-1:0] data_wb;
  logic                           busy_wb;
  logic                           busy_rd;
  // Cache bank refill write port
  logic [ADDR_WIDTH-1:0]          addr_rd;
  logic [2*DATA_WIDTH-1:0]        data_rd;
  logic                           wen_rd;
  logic                           set_rd;
  logic                           finish_rd;
  // Memory side
  logic                           mem_req;
  logic                           mem_wen;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic [2*DATA_WIDTH-1:0]        mem_wdata;
  logic                           mem_ready;
  logic                           mem_rvalid;
  logic [2*DATA_WIDTH-1:0]        mem_rdata;
  logic                           refill_err;

  modport master (
    input  miss_cache, addr_cache, set_cache, need_wb, addr_wb, data_wb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy_wb, busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
    output mem_req, mem_wen, mem_addr, mem_wdata, refill_err
  );

  modport slave (
    output miss_cache, addr_cache, set_cache, need_wb, addr_wb, data_wb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy_wb, busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
    input  mem_req, mem_wen, mem_addr, mem_wdata, refill_err
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-service engine: writes back a dirty victim line, then fetches the new
// line two words per beat and streams it into the cache bank, ending with a
// one-cycle finish strobe. One miss and one memory transaction at a time.
// Optional feature: define CACHE_REFILL_TIMEOUT_EN to add a read-response
// watchdog that aborts the refill and pulses refill_err.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BANK_NUM       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 rstn,
  cache_refill_ctrl_if.master bus
);

  localparam int unsigned Beats     = BANK_NUM / 2;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned BeatDataW = 2 * DATA_WIDTH;
  localparam int unsigned LineW     = BANK_NUM * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BeatBytes = ADDR_WIDTH'(2 * (DATA_WIDTH / 8));
  localparam logic [BeatW-1:0]      LastBeat  = BeatW'(Beats - 1);

  // Parameter sanity checks at elaboration
  if ((BANK_NUM < 2) || ((BANK_NUM % 2) != 0)) begin : g_bad_bank_num
    $error("BANK_NUM must be even and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StRdReq,
    StRdWait,
    StFinish
  } state_e;

  state_e                state_q, state_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic                  set_q, set_d;
  logic [LineW-1:0]      data_wb_q, data_wb_d;
  logic                  busy_wb_q, busy_rd_q;

  logic [ADDR_WIDTH-1:0] beat_off;
  logic [ADDR_WIDTH-1:0] rd_beat_addr;
  logic [ADDR_WIDTH-1:0] wb_beat_addr;
  logic                  to_expired;

  // Beat address offsets wrap modulo 2^ADDR_WIDTH
  assign beat_off     = ADDR_WIDTH'(beat_q) * BeatBytes;
  assign rd_beat_addr = rd_addr_q + beat_off;
  assign wb_beat_addr = wb_addr_q + beat_off;

`ifdef CACHE_REFILL_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Counts RD_WAIT cycles without read data; cleared outside RD_WAIT and on data
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == StRdWait) && !bus.mem_rvalid) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  assign to_expired = (state_q == StRdWait) && !bus.mem_rvalid &&
                      (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  // Next-state, datapath capture and all combinational outputs
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    rd_addr_d      = rd_addr_q;
    wb_addr_d      = wb_addr_q;
    set_d          = set_q;
    data_wb_d      = data_wb_q;
    bus.mem_req    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.wen_rd     = 1'b0;
    bus.addr_rd    = '0;
    bus.data_rd    = '0;
    bus.set_rd     = 1'b0;
    bus.finish_rd  = 1'b0;
    bus.refill_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.miss_cache) begin
          rd_addr_d = bus.addr_cache;
          wb_addr_d = bus.addr_wb;
          set_d     = bus.set_cache;
          data_wb_d = bus.data_wb;
          beat_d    = '0;
          state_d   = bus.need_wb ? StWbReq : StRdReq;
        end
      end

      StWbReq: begin
        bus.mem_req   = 1'b1;
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = wb_beat_addr;
        bus.mem_wdata = data_wb_q[int'(beat_q)*BeatDataW +: BeatDataW];
        if (bus.mem_ready) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StRdReq;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

      StRdReq: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = rd_beat_addr;
        if (bus.mem_ready) begin
          state_d = StRdWait;
        end
      end

      StRdWait: begin
        if (bus.mem_rvalid) begin
          bus.wen_rd  = 1'b1;
          bus.addr_rd = rd_beat_addr;
          bus.data_rd = bus.mem_rdata;
          bus.set_rd  = set_q;
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StFinish;
          end else begin
            beat_d  = beat_q + BeatW'(1);
            state_d = StRdReq;
          end
        end else if (to_expired) begin
          // Abort: the line stays invalid because finish_rd is never raised
          bus.refill_err = 1'b1;
          beat_d         = '0;
          state_d        = StIdle;
        end
      end

      StFinish: begin
        bus.finish_rd = 1'b1;
        bus.addr_rd   = rd_addr_q;
        bus.set_rd    = set_q;
        state_d       = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and beat counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Captured miss context
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_addr_q <= '0;
      wb_addr_q <= '0;
      set_q     <= 1'b0;
      data_wb_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wb_addr_q <= wb_addr_d;
      set_q     <= set_d;
      data_wb_q <= data_wb_d;
    end
  end

  // Registered busy flags, derived from the upcoming state so they block the
  // cache from re-asserting miss_cache right after acceptance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_wb_q <= 1'b0;
      busy_rd_q <= 1'b0;
    end else begin
      busy_wb_q <= (state_d == StWbReq);
      busy_rd_q <= (state_d != StIdle);
    end
  end

  assign bus.busy_wb = busy_wb_q;
  assign bus.busy_rd = busy_rd_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a reactive memory responder.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_cache_refill_ctrl;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned BN = 4;
`ifdef CACHE_REFILL_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 256;
`endif

  logic clk;
  logic rstn;

  cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) bus ();

  cache_refill_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BANK_NUM      (BN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Memory responder knobs and state
  int          ready_lat = 0;
  int          rv_lat = 0;
  bit          rv_en = 1'b1;
  int          req_wait = 0;
  bit          rd_pending = 1'b0;
  int          rv_cnt = 0;
  logic [63:0] rd_addr_m = '0;

  // Monitor state
  int           cyc = 0;
  int           wen_count = 0;
  int           fin_count = 0;
  int           err_count = 0;
  int           first_fin = -1;
  logic [63:0]  last_wen_addr = '0;
  logic [63:0]  rd_log[8];
  int           rd_n = 0;
  int           rise_log[8];
  int           rise_n = 0;
  logic         prev_busy = 1'b0;
  logic         prev_req = 1'b0;
  logic         prev_ready = 1'b0;
  logic         prev_wen = 1'b0;
  logic [63:0]  prev_addr = '0;
  logic [127:0] prev_wdata = '0;
  int           stab_err = 0;
  int           hold_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample and log at negedge+1
  task automatic step(input logic miss, input logic rst_n);
    @(negedge clk);
    rstn = rst_n;
    bus.miss_cache = miss;
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    if (!rst_n) begin
      rd_pending = 1'b0;
      req_wait = 0;
    end else begin
      if (bus.mem_req) begin
        if (req_wait >= ready_lat) bus.mem_ready = 1'b1;
        else req_wait++;
      end
      if (rd_pending && rv_en) begin
        if (rv_cnt >= rv_lat) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = {~rd_addr_m, rd_addr_m};
        end else begin
          rv_cnt++;
        end
      end
    end
    #1;
    cyc++;
    if (bus.wen_rd) begin
      wen_count++;
      last_wen_addr = bus.addr_rd;
    end
    if (bus.finish_rd) begin
      fin_count++;
      if (first_fin < 0) first_fin = cyc;
    end
    if (bus.refill_err) err_count++;
    if (bus.busy_rd && !prev_busy && rise_n < 8) begin
      rise_log[rise_n] = cyc;
      rise_n++;
    end
    prev_busy = bus.busy_rd;
    if (prev_req && !prev_ready) begin
      hold_cnt++;
      if (!(bus.mem_req && bus.mem_addr == prev_addr && bus.mem_wen == prev_wen &&
            bus.mem_wdata == prev_wdata)) stab_err++;
    end
    prev_req = bus.mem_req;
    prev_ready = bus.mem_ready;
    prev_wen = bus.mem_wen;
    prev_addr = bus.mem_addr;
    prev_wdata = bus.mem_wdata;
    if (rst_n) begin
      if (bus.mem_req && bus.mem_ready) begin
        req_wait = 0;
        if (!bus.mem_wen) begin
          rd_pending = 1'b1;
          rv_cnt = 0;
          rd_addr_m = bus.mem_addr;
          if (rd_n < 8) begin
            rd_log[rd_n] = bus.mem_addr;
            rd_n++;
          end
        end
      end
      if (bus.mem_rvalid) rd_pending = 1'b0;
    end
  endtask

  task automatic clear_logs();
    wen_count = 0;
    fin_count = 0;
    first_fin = -1;
    rd_n = 0;
    rise_n = 0;
    cyc = 0;
    stab_err = 0;
    hold_cnt = 0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.miss_cache = 1'b0;
    bus.addr_cache = '0;
    bus.set_cache = 1'b0;
    bus.need_wb = 1'b0;
    bus.addr_wb = '0;
    bus.data_wb = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("rst_busy_rd", bus.busy_rd, 1'b0);
    check("rst_busy_wb", bus.busy_wb, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_wen_rd", bus.wen_rd, 1'b0);
    check("rst_finish_rd", bus.finish_rd, 1'b0);
    check("rst_refill_err", bus.refill_err, 1'b0);
    check("rst_addr_rd", bus.addr_rd, 64'h0);

    // Clean miss, zero-wait memory
    clear_logs();
    bus.addr_cache = 64'h8000_0040;
    bus.set_cache = 1'b1;
    bus.need_wb = 1'b0;
    step(1'b1, 1'b1);
    check("clean_t0_busy_rd", bus.busy_rd, 1'b0);
    step(1'b0, 1'b1);
    check("clean_t1_req", {bus.mem_req, bus.mem_wen}, 2'b10);
    check("clean_t1_addr", bus.mem_addr, 64'h8000_0040);
    check("clean_t1_busy", {bus.busy_rd, bus.busy_wb}, 2'b10);
    step(1'b0, 1'b1);
    check("clean_t2_wen", {bus.wen_rd, bus.set_rd, bus.mem_req}, 3'b110);
    check("clean_t2_addr_rd", bus.addr_rd, 64'h8000_0040);
    check("clean_t2_data_rd", bus.data_rd, {~64'h8000_0040, 64'h8000_0040});
    step(1'b0, 1'b1);
    check("clean_t3_addr", bus.mem_addr, 64'h8000_0050);
    check("clean_t3_req", bus.mem_req, 1'b1);
    step(1'b0, 1'b1);
    check("clean_t4_wen", {bus.wen_rd, bus.set_rd}, 2'b11);
    check("clean_t4_addr_rd", bus.addr_rd, 64'h8000_0050);
    step(1'b0, 1'b1);
    check("clean_t5_finish", {bus.finish_rd, bus.set_rd, bus.busy_rd}, 3'b111);
    check("clean_t5_addr_rd", bus.addr_rd, 64'h8000_0040);
    step(1'b0, 1'b1);
    check("clean_t6_idle", {bus.finish_rd, bus.busy_rd, bus.mem_req}, 3'b000);

    // Dirty miss
    clear_logs();
    bus.addr_cache = 64'h8000_0080;
    bus.set_cache = 1'b0;
    bus.need_wb = 1'b1;
    bus.addr_wb = 64'h1000_0000;
    bus.data_wb = {64'hD, 64'hC, 64'hB, 64'hA};
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("dirty_t1_req", {bus.mem_req, bus.mem_wen, bus.busy_wb, bus.busy_rd}, 4'b1111);
    check("dirty_t1_addr", bus.mem_addr, 64'h1000_0000);
    check("dirty_t1_wdata", bus.mem_wdata, {64'hB, 64'hA});
    step(1'b0, 1'b1);
    check("dirty_t2_addr", bus.mem_addr, 64'h1000_0010);
    check("dirty_t2_wdata", bus.mem_wdata, {64'hD, 64'hC});
    check("dirty_t2_busy_wb", bus.busy_wb, 1'b1);
    step(1'b0, 1'b1);
    check("dirty_t3_rd", {bus.mem_req, bus.mem_wen, bus.busy_wb}, 3'b100);
    check("dirty_t3_addr", bus.mem_addr, 64'h8000_0080);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("dirty_t7_finish", {bus.finish_rd, bus.set_rd}, 2'b10);
    check("dirty_wen_count", wen_count, 2);
    step(1'b0, 1'b1);
    check("dirty_t8_busy_rd", bus.busy_rd, 1'b0);

    // Back-pressure: ready low 3 cycles per beat, rvalid 5 cycles late
    clear_logs();
    ready_lat = 3;
    rv_lat = 5;
    bus.addr_cache = 64'h4000_0000;
    bus.set_cache = 1'b1;
    bus.need_wb = 1'b0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 60 && fin_count == 0; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("bp_wen_count", wen_count, 2);
    check("bp_fin_count", fin_count, 1);
    check("bp_stable", stab_err, 0);
    check("bp_hold_cycles", hold_cnt, 6);
    check("bp_rd_addr0", rd_log[0], 64'h4000_0000);
    check("bp_rd_addr1", rd_log[1], 64'h4000_0010);
    ready_lat = 0;
    rv_lat = 0;

    // Reset mid-refill after the first refill beat
    clear_logs();
    bus.addr_cache = 64'h2000_0000;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rmid_first_wen", bus.wen_rd, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("rmid_outputs", {bus.mem_req, bus.busy_rd, bus.busy_wb, bus.wen_rd,
                           bus.finish_rd, bus.refill_err}, 6'b0);
    check("rmid_addr", {bus.mem_addr, bus.addr_rd}, 128'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check("rmid_no_finish", fin_count, 0);
    check("rmid_wen_count", wen_count, 1);
    bus.addr_cache = 64'h2000_0100;
    step(1'b1, 1'b1);
    for (int i = 0; i < 20 && fin_count == 0; i++) step(1'b0, 1'b1);
    check("rmid_next_finish", fin_count, 1);
    check("rmid_next_wen", wen_count, 3);
    check("rmid_next_last_addr", last_wen_addr, 64'h2000_0110);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Busy gating: miss_cache held high continuously
    clear_logs();
    bus.addr_cache = 64'h3000_0000;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("gate_fin_count", fin_count, 3);
    check("gate_wen_count", wen_count, 6);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    check("gate_fin_total", fin_count, 4);
    check("gate_wen_total", wen_count, 8);
    check("gate_accepts", rise_n, 4);
    check("gate_period", rise_log[1] - rise_log[0], 6);
    check("gate_after_finish", rise_log[1] - first_fin, 2);

`ifdef CACHE_REFILL_TIMEOUT_EN
    // Watchdog: withhold read data; abort on cycle 16 of RD_WAIT
    clear_logs();
    rv_en = 1'b0;
    bus.addr_cache = 64'h5000_0000;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    check("to_no_early_err", err_count, 0);
    step(1'b0, 1'b1);
    check("to_err_pulse", {bus.refill_err, bus.finish_rd}, 2'b10);
    step(1'b0, 1'b1);
    check("to_idle", {bus.busy_rd, bus.mem_req, bus.refill_err}, 3'b000);
    check("to_no_finish", fin_count, 0);
    rd_pending = 1'b0;
    rv_en = 1'b1;
    check("err_total", err_count, 1);
`else
    check("err_total", err_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-service engine on the far end of the cache bank's miss/refill interface. Accepts a line-miss request (with optional dirty victim) from the 2-way cache bank, writes the victim back to memory, fetches the new line two words per beat, and streams the beats into the bank via the refill write port, closing with a one-cycle finish strobe. It sits between the cache bank and the memory/bus adapter and serves one miss at a time.

## Interface
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, cache word width; a memory beat is 2*DATA_WIDTH.
- BANK_NUM, 4, words per line; must be even and at least 2; BEATS = BANK_NUM/2.
- TIMEOUT_CYCLES, 256, read-response watchdog limit; used only with CACHE_REFILL_TIMEOUT_EN.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  reset; synchronous, active-low.
- miss_cache  in  1  cache requests a refill; sampled only in IDLE.
- addr_cache  in  ADDR_WIDTH  line-aligned refill address.
- set_cache  in  1  victim way.
- need_wb  in  1  victim is dirty.
- addr_wb  in  ADDR_WIDTH  line-aligned victim address.
- data_wb  in  BANK_NUM*DATA_WIDTH  victim line; word 0 in the LSBs.
- busy_wb  out  1  writeback in progress.
- busy_rd  out  1  refill in progress.
- addr_rd  out  ADDR_WIDTH  refill beat address.
- data_rd  out  2*DATA_WIDTH  refill beat; lower word at the lower address.
- wen_rd  out  1  refill beat write strobe.
- set_rd  out  1  way being refilled.
- finish_rd  out  1  line complete; the cache sets valid.
- mem_req  out  1  memory request valid.
- mem_wen  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_wdata  out  2*DATA_WIDTH  write beat data.
- mem_ready  in  1  memory accepts the request in this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  2*DATA_WIDTH  read data.
- refill_err  out  1  one-cycle pulse when the watchdog aborts a refill; tied 0 without the macro.

## Operation
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, FINISH.
- IDLE, when miss_cache=1:
  - Capture addr_cache, set_cache, need_wb, addr_wb and data_wb.
  - Clear the beat counter.
  - Go to WB_REQ if need_wb=1, otherwise go to RD_REQ.
- WB_REQ:
  - Drive mem_req=1, mem_wen=1.
  - mem_addr = wb_addr + beat*2*(DATA_WIDTH/8).
  - mem_wdata = data_wb bits [beat*2*DATA_WIDTH +: 2*DATA_WIDTH].
  - On mem_ready, increment beat. After the last beat, clear beat and go to RD_REQ.
- RD_REQ:
  - Drive mem_req=1, mem_wen=0, mem_addr = rd_addr + beat*2*(DATA_WIDTH/8).
  - Go to RD_WAIT on mem_ready.
- RD_WAIT, on mem_rvalid:
  - Drive wen_rd=1 for exactly that cycle, combinationally.
  - addr_rd = the same beat address; data_rd = mem_rdata; set_rd = captured way.
  - Increment beat. Go to FINISH after the last beat, otherwise back to RD_REQ.
- FINISH:
  - Drive finish_rd=1 for one cycle, with addr_rd = rd_addr and set_rd = captured way.
  - Go to IDLE.
- One outstanding memory transaction only. mem_rvalid is ignored outside RD_WAIT.
- Beat addresses are computed modulo 2^ADDR_WIDTH. The beat counter is $clog2(BEATS) bits, with a minimum of 1 bit.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-operation: abandon the transfer at the next clock edge; no wen_rd and no finish_rd are issued.
- busy_wb and busy_rd are registered:
  - busy_wb=1 while in WB_REQ.
  - busy_rd=1 from the cycle after acceptance through the FINISH cycle inclusive.
  - Both are 0 in IDLE.
- Acceptance cycle: miss_cache is high for exactly one cycle per miss, because registered busy blocks the cache's next assertion.
- Latency:
  - Acceptance at cycle T; the first mem_req is at T+1.
  - With zero-wait memory (mem_ready=1, mem_rvalid one cycle after accept), a clean refill takes 1+2*BEATS+1 cycles to finish_rd.
  - A dirty refill adds BEATS cycles.
- mem_req, mem_addr, mem_wdata and mem_wen stay stable until mem_ready.
- mem_req=0 in RD_WAIT, FINISH and IDLE.

## Configuration
- CACHE_REFILL_TIMEOUT_EN defined:
  - A counter in RD_WAIT counts cycles without mem_rvalid.
  - On reaching TIMEOUT_CYCLES, pulse refill_err for one cycle and go to IDLE without finish_rd, leaving the line invalid.
  - The counter clears on every mem_rvalid and on state entry.
- Not defined: RD_WAIT waits indefinitely, no counter logic exists, and refill_err is tied 0.

## Test plan
- Clean miss: DATA_WIDTH=64, BANK_NUM=4, addr_cache=0x8000_0040, set_cache=1, need_wb=0, zero-wait memory -> reads at 0x8000_0040 and 0x8000_0050. wen_rd fires twice with set_rd=1, then finish_rd with addr_rd=0x8000_0040; busy_rd deasserts the cycle after finish_rd.
- Dirty miss: need_wb=1, addr_wb=0x1000_0000, data_wb={4 words 0xD,0xC,0xB,0xA} -> write beats to 0x1000_0000 with wdata {0xB,0xA} and to 0x1000_0010 with wdata {0xD,0xC}, busy_wb=1 for those cycles, then the clean read sequence.
- Back-pressure: mem_ready low 3 cycles per beat, rvalid 5 cycles late -> request signals are held stable, exactly 2 wen_rd pulses, exactly 1 finish_rd.
- Reset mid-refill: assert rstn=0 after the first wen_rd -> all outputs are 0 next cycle and no finish_rd follows; a subsequent miss completes normally.
- Busy gating: hold miss_cache=1 continuously -> exactly one miss is accepted per refill, and the next one is accepted only in IDLE after busy_rd clears.
- With CACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold mem_rvalid -> refill_err pulses on cycle 16 of RD_WAIT, no finish_rd is issued, and the state returns to IDLE.
